// File: rtl/imm_pkg.sv
// imm_pkg: immediate format encodings and RV32 opcode constants
package imm_pkg;
  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_J    = 3'b011;
  localparam logic [2:0] FMT_U    = 3'b100;
  localparam logic [2:0] FMT_AUTO = 3'b111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
endpackage

// File: rtl/imm_fmt_decode.sv
// imm_fmt_decode: resolves the format select (or opcode in AUTO mode) to a concrete format
module imm_fmt_decode
  import imm_pkg::*;
#(
  parameter bit AUTO_EN = 1'b1
) (
  input  logic [2:0] src,
  input  logic [6:0] opcode,
  output logic [2:0] fmt,
  output logic       illegal
);
  logic [2:0] auto_fmt;
  logic       auto_hit;
  logic       auto_sel;
  always_comb begin
    auto_fmt = FMT_I;
    auto_hit = 1'b1;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: auto_fmt = FMT_I;
      OP_STORE:                            auto_fmt = FMT_S;
      OP_BRANCH:                           auto_fmt = FMT_B;
      OP_JAL:                              auto_fmt = FMT_J;
      OP_LUI, OP_AUIPC:                    auto_fmt = FMT_U;
      default:                             auto_hit = 1'b0;
    endcase
  end
  assign auto_sel = src == FMT_AUTO;
  // illegal entries always report format I so the output never carries a stale code
  assign illegal  = auto_sel ? !(AUTO_EN && auto_hit) : src > FMT_U;
  assign fmt      = illegal ? FMT_I : auto_sel ? auto_fmt : src;
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage valid/ready pipeline building sign-extended RV32 immediates
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit AUTO_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      src,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic [2:0]      fmt,
  output logic            illegal
);
  logic        s1_valid;
  logic [31:7] s1_instr;
  logic [2:0]  s1_fmt;
  logic        s1_illegal;
  logic [2:0]  dec_fmt;
  logic        dec_illegal;
  logic [31:0] imm32;
  logic        s2_load;
  logic        accept;
  imm_fmt_decode #(.AUTO_EN(AUTO_EN)) u_dec (
    .src     (src),
    .opcode  (instr[6:0]),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = rst_n && !flush && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;
  assign imm32 = s1_illegal          ? '0 :
                 s1_fmt == FMT_S     ? {{20{s1_instr[31]}}, s1_instr[31:25], s1_instr[11:7]} :
                 s1_fmt == FMT_B     ? {{19{s1_instr[31]}}, s1_instr[31], s1_instr[7], s1_instr[30:25], s1_instr[11:8], 1'b0} :
                 s1_fmt == FMT_J     ? {{11{s1_instr[31]}}, s1_instr[31], s1_instr[19:12], s1_instr[20], s1_instr[30:21], 1'b0} :
                 s1_fmt == FMT_U     ? {s1_instr[31:12], 12'b0} :
                                       {{20{s1_instr[31]}}, s1_instr[31:20]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_instr   <= '0;
      s1_fmt     <= FMT_I;
      s1_illegal <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      if (!s1_valid || s2_load) s1_valid <= accept;
      if (accept) begin
        s1_instr   <= instr[31:7];
        s1_fmt     <= dec_fmt;
        s1_illegal <= dec_illegal;
      end
    end
  end
  // U already sits in bits 31:12, so one signed widening covers every format at XLEN=64
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      imm_ext   <= '0;
      fmt       <= FMT_I;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        imm_ext <= XLEN'($signed(imm32));
        fmt     <= s1_fmt;
        illegal <= s1_illegal;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving 32- and 64-bit instances with identical directed vectors
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  src = '0;
  logic        in_ready, out_valid, illegal;
  logic        in_ready64, out_valid64, illegal64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt, fmt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_EN(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .src(src), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .imm_ext(imm32), .fmt(fmt), .illegal(illegal)
  );
  imm_gen_pipe #(.XLEN(64), .AUTO_EN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64), .instr(instr),
    .src(src), .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
    .imm_ext(imm64), .fmt(fmt64), .illegal(illegal64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int checks = 0;
  int failures = 0;

  logic [31:0] v_instr [16] = '{32'h7FF00093, 32'hFE112C23, 32'hFE112C23, 32'hFE000EE3,
                                32'hFFFFF06F, 32'hFFFFF06F, 32'h12345037, 32'h00001017,
                                32'h00100073, 32'hFFF0A083, 32'h0010006F, 32'h00000033,
                                32'hFFF00093, 32'hFFF00093, 32'h800000B7, 32'h00008067};
  logic [2:0]  v_src   [16] = '{3'd0, 3'd1, 3'd7, 3'd2, 3'd3, 3'd7, 3'd7, 3'd7,
                                3'd7, 3'd7, 3'd0, 3'd7, 3'd5, 3'd6, 3'd4, 3'd7};
  logic [63:0] v_imm   [16] = '{64'h7FF, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
                                64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 64'h12345000, 64'h1000,
                                64'h1, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0,
                                64'h0, 64'h0, 64'hFFFFFFFF80000000, 64'h0};
  logic [2:0]  v_fmt   [16] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4,
                                3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0};
  logic        v_ill   [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops on every consumed output and checks held values during stalls
  logic [63:0] h_imm;
  logic [2:0]  h_fmt;
  logic        h_ill;
  bit          stalled = 1'b0;
  always @(negedge clk) begin
    if (out_valid64 !== out_valid) chk("valid_sync", {63'b0, out_valid64}, {63'b0, out_valid});
    if (in_ready64 !== in_ready) chk("ready_sync", {63'b0, in_ready64}, {63'b0, in_ready});
    if (out_valid && out_ready && !flush) begin
      if (q.size() == 0) chk("unexpected_output", {63'b0, out_valid}, 64'd0);
      else begin
        e_mon = q.pop_front();
        chk("imm32", {32'b0, imm32}, {32'b0, e_mon.imm[31:0]});
        chk("imm64", imm64, e_mon.imm);
        chk("fmt32", {61'b0, fmt}, {61'b0, e_mon.fmt});
        chk("fmt64", {61'b0, fmt64}, {61'b0, e_mon.fmt});
        chk("illegal32", {63'b0, illegal}, {63'b0, e_mon.ill});
        chk("illegal64", {63'b0, illegal64}, {63'b0, e_mon.ill});
      end
    end
    if (out_valid && !out_ready) begin
      if (stalled) begin
        chk("hold_imm", imm64, h_imm);
        chk("hold_fmt", {61'b0, fmt64}, {61'b0, h_fmt});
        chk("hold_illegal", {63'b0, illegal64}, {63'b0, h_ill});
      end
      stalled = 1'b1;
      h_imm = imm64;
      h_fmt = fmt64;
      h_ill = illegal64;
    end else stalled = 1'b0;
  end

  task automatic send(input logic [31:0] ins, input logic [2:0] s, input logic [63:0] ei,
                      input logic [2:0] ef, input logic el);
    exp_t e;
    int n = 0;
    instr = ins;
    src = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
    else begin
      e.imm = ei;
      e.fmt = ef;
      e.ill = el;
      q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic lat_send(input string name, input logic [31:0] ins, input logic [2:0] s,
                          input logic [63:0] ei, input logic [2:0] ef);
    send(ins, s, ei, ef, 1'b0);
    @(negedge clk);
    chk({name, "_cycle1"}, {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    chk({name, "_cycle2"}, {63'b0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_fmt", {61'b0, fmt}, 64'd0);
    chk("rst_illegal", {63'b0, illegal}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    lat_send("lat_addi", 32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd0);
    for (int i = 0; i < 16; i++) send(v_instr[i], v_src[i], v_imm[i], v_fmt[i], v_ill[i]);
    drain();
    // backpressure: two accepted, third waits while the head is held
    out_ready = 1'b0;
    send(32'hFE000EE3, 3'd7, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    send(32'h0010006F, 3'd7, 64'h800, 3'd3, 1'b0);
    fork
      send(32'h800000B7, 3'd4, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
      begin
        @(negedge clk);
        chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    // flush with two in flight, out_ready high and a new input presented
    out_ready = 1'b0;
    send(32'h7FF00093, 3'd0, 64'h7FF, 3'd0, 1'b0);
    send(32'h12345037, 3'd7, 64'h12345000, 3'd4, 1'b0);
    flush = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    instr = 32'hFFF00093;
    src = 3'd0;
    @(negedge clk);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_no_stale", {63'b0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    lat_send("lat_after_flush", 32'hFE112C23, 3'd7, 64'hFFFFFFFFFFFFFFF8, 3'd1);
    drain();
    // reset pulse with two in flight
    out_ready = 1'b0;
    send(32'hFFFFF06F, 3'd7, 64'hFFFFFFFFFFFFFFFE, 3'd3, 1'b0);
    send(32'h00001017, 3'd7, 64'h1000, 3'd4, 1'b0);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", {63'b0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    lat_send("lat_after_rst", 32'h0010006F, 3'd7, 64'h800, 3'd3);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
